// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the 8086-style memory/I/O bus slave.
package mem_io_pkg;

  // Width of the wait-state counter (wait counts 0..15).
  localparam int WAIT_W = 4;

  // Bus-cycle phases seen by the slave.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    XFER = 2'd3
  } bus_state_t;

  // Byte-lane enables for a 16-bit bus: bit0 = low lane, bit1 = high lane.
  function automatic logic [1:0] lanes(input logic a0, input logic bhe_n);
    lanes = {~bhe_n, ~a0};
  endfunction

endpackage

// File: rtl/mem_io_bank.sv
// Byte-lane RAM: synchronous read, per-lane write enable, contents never reset.
module mem_io_bank #(
  parameter int AW     = 16,
  parameter int DATA_W = 16
) (
  input  logic                              CLK,
  input  logic [AW-((DATA_W==16)?1:0)-1:0]  waddr,
  input  logic [AW-((DATA_W==16)?1:0)-1:0]  raddr,
  input  logic [DATA_W/8-1:0]               we,
  input  logic [DATA_W-1:0]                 wdata,
  output logic [DATA_W-1:0]                 rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFFS  = (DATA_W == 16) ? 1 : 0;
  localparam int WAW   = AW - OFFS;
  localparam int DEPTH = 1 << WAW;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Commit enabled byte lanes and register the addressed word for reading.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) begin
        mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_io_bus_slave.sv
// 8086-style bus slave with separate memory and I/O spaces and programmable
// wait states. Address/space are latched on ALE; one RD_N or WR_N strobe is
// served per bus cycle; READY is held low while wait states are inserted.
module mem_io_bus_slave
  import mem_io_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int MEM_AW   = 16,
  parameter int IO_AW    = 8,
  parameter int MEM_WAIT = 1,
  parameter int IO_WAIT  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CS,
  input  logic              ALE,
  input  logic              IOM,
  input  logic [ADDR_W-1:0] Address,
  input  logic              BHE_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOE,
  output logic              READY,
  output logic              ERR
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFS = (DATA_W == 16) ? 1 : 0;
  localparam logic [WAIT_W-1:0] MEM_WAIT_C = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_WAIT_C  = WAIT_W'(IO_WAIT);

  bus_state_t        state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_d_s;
  logic              iom_r, iom_d_s;
  logic              bhe_n_r, bhe_n_d_s;
  logic              wr_r, wr_s;
  logic [WAIT_W-1:0] cnt_r, cnt_s, load_cnt_s;

  logic              rd_s, wr_strobe_s, one_strobe_s, both_strobe_s;
  logic              latch_s, both_err_s, enter_xfer_s;
  logic              range_err_s, xfer_err_s, ready_s;
  logic [1:0]        lane_pair_s;
  logic [NB-1:0]     lane_en_s, mem_we_s, io_we_s;
  logic [DATA_W-1:0] lane_mask_s, mem_rdata_s, io_rdata_s, rsel_s;

  logic [DATA_W-1:0] dataout_r;
  logic              dataoe_r, ready_r, err_r;

  assign rd_s          = ~RD_N;
  assign wr_strobe_s   = ~WR_N;
  assign one_strobe_s  = rd_s ^ wr_strobe_s;
  assign both_strobe_s = rd_s & wr_strobe_s;

  // A new address is taken in IDLE, or in ADDR when ALE returns before any strobe.
  assign latch_s = ALE && CS &&
                   ((state_r == IDLE) || ((state_r == ADDR) && !rd_s && !wr_strobe_s));

  assign addr_d_s  = latch_s ? Address : addr_r;
  assign iom_d_s   = latch_s ? IOM     : iom_r;
  assign bhe_n_d_s = latch_s ? BHE_N   : bhe_n_r;

  // Wait count follows the space being (or already) latched.
  assign load_cnt_s = iom_d_s ? IO_WAIT_C : MEM_WAIT_C;

  assign lane_pair_s = lanes(addr_r[0], bhe_n_r);

  generate
    if (NB == 2) begin : g_lane16
      assign lane_en_s = lane_pair_s;
    end else begin : g_lane8
      assign lane_en_s = 1'b1;
    end
  endgenerate

  // Anything at or above the selected space size is out of range.
  assign range_err_s = iom_r ? ((addr_r >> IO_AW)  != {ADDR_W{1'b0}})
                             : ((addr_r >> MEM_AW) != {ADDR_W{1'b0}});
  assign xfer_err_s  = range_err_s || (lane_en_s == {NB{1'b0}});

  // Next-state logic for the bus-cycle FSM.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    wr_s       = wr_r;
    both_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (latch_s) state_s = ADDR;
        else         state_s = IDLE;
      end
      ADDR: begin
        if (both_strobe_s) begin
          both_err_s = 1'b1;
          state_s    = IDLE;
        end else if (one_strobe_s) begin
          wr_s  = wr_strobe_s;
          cnt_s = load_cnt_s;
          if (load_cnt_s == {WAIT_W{1'b0}}) state_s = XFER;
          else                              state_s = WAIT;
        end else begin
          state_s = ADDR;
        end
      end
      WAIT: begin
        if (cnt_r <= WAIT_W'(1)) begin
          state_s = XFER;
        end else begin
          cnt_s   = cnt_r - WAIT_W'(1);
          state_s = WAIT;
        end
      end
      XFER: begin
        if (wr_r ? wr_strobe_s : rd_s) state_s = XFER;
        else                           state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // READY for the coming cycle: low while waiting, high when no wait is needed.
  always_comb begin
    ready_s = 1'b1;
    case (state_s)
      ADDR:    ready_s = (state_r == IDLE) && one_strobe_s &&
                         (load_cnt_s == {WAIT_W{1'b0}});
      WAIT:    ready_s = 1'b0;
      default: ready_s = 1'b1;
    endcase
  end

  // Writes land exactly once, on the edge that enters XFER; reset blocks them.
  assign enter_xfer_s = (state_s == XFER) && (state_r != XFER) && !RESET;
  assign mem_we_s = (enter_xfer_s && wr_s && !iom_r && !xfer_err_s) ? lane_en_s : {NB{1'b0}};
  assign io_we_s  = (enter_xfer_s && wr_s &&  iom_r && !xfer_err_s) ? lane_en_s : {NB{1'b0}};

  // Read data only carries the enabled lanes; other lanes read as zero.
  always_comb begin
    lane_mask_s = {DATA_W{1'b0}};
    for (int b = 0; b < NB; b++) begin
      lane_mask_s[b*8 +: 8] = {8{lane_en_s[b]}};
    end
  end

  assign rsel_s = iom_r ? io_rdata_s : mem_rdata_s;

  mem_io_bank #(.AW(MEM_AW), .DATA_W(DATA_W)) u_mem_bank (
    .CLK   (CLK),
    .waddr (addr_r[MEM_AW-1:OFFS]),
    .raddr (addr_d_s[MEM_AW-1:OFFS]),
    .we    (mem_we_s),
    .wdata (DataIn),
    .rdata (mem_rdata_s)
  );

  mem_io_bank #(.AW(IO_AW), .DATA_W(DATA_W)) u_io_bank (
    .CLK   (CLK),
    .waddr (addr_r[IO_AW-1:OFFS]),
    .raddr (addr_d_s[IO_AW-1:OFFS]),
    .we    (io_we_s),
    .wdata (DataIn),
    .rdata (io_rdata_s)
  );

  // FSM state, wait counter and direction registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      cnt_r   <= {WAIT_W{1'b0}};
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      wr_r    <= wr_s;
    end
  end

  // Address/space/byte-high latch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_r  <= {ADDR_W{1'b0}};
      iom_r   <= 1'b0;
      bhe_n_r <= 1'b1;
    end else begin
      addr_r  <= addr_d_s;
      iom_r   <= iom_d_s;
      bhe_n_r <= bhe_n_d_s;
    end
  end

  // Registered bus outputs; read data is captured on entry to XFER.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dataout_r <= {DATA_W{1'b0}};
      dataoe_r  <= 1'b0;
      ready_r   <= 1'b1;
      err_r     <= 1'b0;
    end else begin
      ready_r  <= ready_s;
      dataoe_r <= (state_s == XFER) && !wr_s;
      err_r    <= both_err_s || (enter_xfer_s && xfer_err_s);
      if (enter_xfer_s && !wr_s) begin
        dataout_r <= xfer_err_s ? {DATA_W{1'b1}} : (rsel_s & lane_mask_s);
      end else begin
        dataout_r <= dataout_r;
      end
    end
  end

  assign DataOut = dataout_r;
  assign DataOE  = dataoe_r;
  assign READY   = ready_r;
  assign ERR     = err_r;

endmodule

// File: tb/tb_mem_io_bus_slave.sv
// Self-checking bench for mem_io_bus_slave: a default build (MEM_WAIT=1,
// IO_WAIT=2) and a zero-memory-wait build share the bus wires but have
// separate chip selects. Expected read data goes through a scoreboard queue.
module tb_mem_io_bus_slave;

  logic        CLK = 1'b0;
  logic        RESET, cs_a, cs_b, ALE, IOM, BHE_N, RD_N, WR_N;
  logic [19:0] Address;
  logic [15:0] DataIn;
  logic [15:0] dout_a, dout_b;
  logic        oe_a, oe_b, rdy_a, rdy_b, err_a, err_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] m;
  } exp_t;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  mem_io_bus_slave u_dut (
    .CLK(CLK), .RESET(RESET), .CS(cs_a), .ALE(ALE), .IOM(IOM), .Address(Address),
    .BHE_N(BHE_N), .RD_N(RD_N), .WR_N(WR_N), .DataIn(DataIn),
    .DataOut(dout_a), .DataOE(oe_a), .READY(rdy_a), .ERR(err_a)
  );

  mem_io_bus_slave #(.MEM_WAIT(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .CS(cs_b), .ALE(ALE), .IOM(IOM), .Address(Address),
    .BHE_N(BHE_N), .RD_N(RD_N), .WR_N(WR_N), .DataIn(DataIn),
    .DataOut(dout_b), .DataOE(oe_b), .READY(rdy_b), .ERR(err_b)
  );

  // One bus cycle: ALE and strobe driven together, strobe held for 6 edges,
  // then released. Reports READY-low samples, ERR samples, the sample index
  // where DataOE first rose, the data seen there, and DataOE after release.
  task automatic bus_cycle(input bit sel, input bit cs, input bit iom, input logic [19:0] a,
                           input bit bhe_n, input bit rd, input bit wr, input logic [15:0] wd,
                           output int rlow, output int errs, output int first_oe,
                           output logic [15:0] rdata, output logic oe_after);
    logic        r, e, o;
    logic [15:0] d;
    @(negedge CLK);
    ALE = 1'b1; IOM = iom; Address = a; BHE_N = bhe_n;
    RD_N = !rd; WR_N = !wr; DataIn = wd;
    if (sel) cs_b = cs; else cs_a = cs;
    rlow = 0; errs = 0; first_oe = 0; rdata = 16'h0000;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK); #1;
      r = sel ? rdy_b  : rdy_a;
      e = sel ? err_b  : err_a;
      o = sel ? oe_b   : oe_a;
      d = sel ? dout_b : dout_a;
      if (r !== 1'b1) rlow++;
      if (e !== 1'b0) errs++;
      if (o === 1'b1 && first_oe == 0) begin
        first_oe = i;
        rdata    = d;
      end
      if (i == 1) begin
        ALE = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
      end
    end
    RD_N = 1'b1; WR_N = 1'b1;
    @(posedge CLK); #1;
    oe_after = sel ? oe_b : oe_a;
  endtask

  // Read cycle whose expected data is queued before the stimulus is driven.
  task automatic read_cycle(input bit sel, input bit iom, input logic [19:0] a, input bit bhe_n,
                            input logic [15:0] exp_d, input logic [15:0] exp_m,
                            output int rlow, output int errs, output int first_oe,
                            output logic [15:0] rdata, output logic oe_after);
    exp_t ent;
    ent.d = exp_d;
    ent.m = exp_m;
    sb_q.push_back(ent);
    bus_cycle(sel, 1'b1, iom, a, bhe_n, 1'b1, 1'b0, 16'h0000, rlow, errs, first_oe, rdata, oe_after);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({rdy_a, oe_a, err_a, dout_a} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_a: rdy=%b oe=%b err=%b dout=%h want 1 0 0 0000", rdy_a, oe_a, err_a, dout_a);
    end
    total++;
    if ({rdy_b, oe_b, err_b, dout_b} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_b: rdy=%b oe=%b err=%b dout=%h want 1 0 0 0000", rdy_b, oe_b, err_b, dout_b);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_mem_rw();
    int rl, er, fo; logic [15:0] rd; logic oa; exp_t ex;
    bus_cycle(1'b0, 1'b1, 1'b0, 20'h00010, 1'b0, 1'b0, 1'b1, 16'hBEEF, rl, er, fo, rd, oa);
    total++;
    if (rl !== 2 || er !== 0) begin
      bad++; $display("FAIL mem_write: ready_low=%0d err=%0d want 2 0", rl, er);
    end
    read_cycle(1'b0, 1'b0, 20'h00010, 1'b0, 16'hBEEF, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m)) begin
      bad++; $display("FAIL mem_read_data: got=%h oe_at=%0d want=%h", rd, fo, ex.d);
    end
    total++;
    if (rl !== 2 || fo !== 3 || oa !== 1'b0) begin
      bad++; $display("FAIL mem_read_timing: ready_low=%0d oe_at=%0d oe_after=%b want 2 3 0", rl, fo, oa);
    end
  endtask

  task automatic test_io_lanes();
    int rl, er, fo; logic [15:0] rd; logic oa; exp_t ex;
    bus_cycle(1'b0, 1'b1, 1'b0, 20'h00040, 1'b0, 1'b0, 1'b1, 16'h1111, rl, er, fo, rd, oa);
    bus_cycle(1'b0, 1'b1, 1'b1, 20'h00041, 1'b0, 1'b0, 1'b1, 16'h5A00, rl, er, fo, rd, oa);
    total++;
    if (rl !== 3 || er !== 0) begin
      bad++; $display("FAIL io_write: ready_low=%0d err=%0d want 3 0", rl, er);
    end
    read_cycle(1'b0, 1'b0, 20'h00040, 1'b0, 16'h1111, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m)) begin
      bad++; $display("FAIL mem_no_alias: got=%h oe_at=%0d want=%h", rd, fo, ex.d);
    end
    read_cycle(1'b0, 1'b1, 20'h00040, 1'b0, 16'h5A00, 16'hFF00, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m)) begin
      bad++; $display("FAIL io_read_hi: got=%h oe_at=%0d want_hi=%h", rd, fo, ex.d);
    end
    total++;
    if (rl !== 3 || fo !== 4) begin
      bad++; $display("FAIL io_read_timing: ready_low=%0d oe_at=%0d want 3 4", rl, fo);
    end
    read_cycle(1'b0, 1'b1, 20'h00041, 1'b0, 16'h5A00, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m)) begin
      bad++; $display("FAIL io_read_hi_only: got=%h oe_at=%0d want=%h", rd, fo, ex.d);
    end
  endtask

  task automatic test_both_strobes();
    int rl, er, fo; logic [15:0] rd; logic oa; exp_t ex;
    bus_cycle(1'b0, 1'b1, 1'b0, 20'h00030, 1'b0, 1'b0, 1'b1, 16'h7777, rl, er, fo, rd, oa);
    bus_cycle(1'b0, 1'b1, 1'b0, 20'h00030, 1'b0, 1'b1, 1'b1, 16'h0000, rl, er, fo, rd, oa);
    total++;
    if (er !== 1 || rl !== 1 || fo !== 0) begin
      bad++; $display("FAIL both_strobes: err=%0d ready_low=%0d oe_at=%0d want 1 1 0", er, rl, fo);
    end
    read_cycle(1'b0, 1'b0, 20'h00030, 1'b0, 16'h7777, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m) || er !== 0) begin
      bad++; $display("FAIL both_strobes_nowrite: got=%h oe_at=%0d err=%0d want=%h", rd, fo, er, ex.d);
    end
  endtask

  task automatic test_range();
    int rl, er, fo; logic [15:0] rd; logic oa; exp_t ex;
    read_cycle(1'b0, 1'b0, 20'h20000, 1'b0, 16'hFFFF, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || rd !== ex.d || er !== 1 || rl !== 2 || oa !== 1'b0) begin
      bad++; $display("FAIL mem_range: got=%h err=%0d ready_low=%0d oe_after=%b want %h 1 2 0", rd, er, rl, oa, ex.d);
    end
    read_cycle(1'b0, 1'b1, 20'h00100, 1'b0, 16'hFFFF, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || rd !== ex.d || er !== 1 || rl !== 3) begin
      bad++; $display("FAIL io_range: got=%h err=%0d ready_low=%0d want %h 1 3", rd, er, rl, ex.d);
    end
    bus_cycle(1'b0, 1'b1, 1'b0, 20'h00011, 1'b1, 1'b0, 1'b1, 16'h0000, rl, er, fo, rd, oa);
    total++;
    if (er !== 1 || rl !== 2) begin
      bad++; $display("FAIL no_lane_write: err=%0d ready_low=%0d want 1 2", er, rl);
    end
    read_cycle(1'b0, 1'b0, 20'h00010, 1'b0, 16'hBEEF, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m) || er !== 0) begin
      bad++; $display("FAIL no_lane_dropped: got=%h err=%0d want=%h", rd, er, ex.d);
    end
  endtask

  task automatic test_reset_mid_cycle();
    int rl, er, fo; logic [15:0] rd; logic oa; exp_t ex;
    @(negedge CLK);
    ALE = 1'b1; cs_a = 1'b1; IOM = 1'b0; Address = 20'h00010; BHE_N = 1'b0;
    WR_N = 1'b0; RD_N = 1'b1; DataIn = 16'h1234;
    @(posedge CLK); #1;
    ALE = 1'b0; cs_a = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (rdy_a !== 1'b0) begin
      bad++; $display("FAIL reset_mid_inwait: ready=%b want 0", rdy_a);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (rdy_a !== 1'b1 || oe_a !== 1'b0) begin
      bad++; $display("FAIL reset_mid_outputs: ready=%b oe=%b want 1 0", rdy_a, oe_a);
    end
    RESET = 1'b0; WR_N = 1'b1;
    read_cycle(1'b0, 1'b0, 20'h00010, 1'b0, 16'hBEEF, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m)) begin
      bad++; $display("FAIL reset_mid_nowrite: got=%h oe_at=%0d want=%h", rd, fo, ex.d);
    end
  endtask

  task automatic test_zero_wait();
    int rl, er, fo; logic [15:0] rd; logic oa; exp_t ex;
    bus_cycle(1'b1, 1'b1, 1'b0, 20'h00100, 1'b0, 1'b0, 1'b1, 16'hCAFE, rl, er, fo, rd, oa);
    total++;
    if (rl !== 0 || er !== 0) begin
      bad++; $display("FAIL zw_write: ready_low=%0d err=%0d want 0 0", rl, er);
    end
    read_cycle(1'b1, 1'b0, 20'h00100, 1'b0, 16'hCAFE, 16'hFFFF, rl, er, fo, rd, oa);
    ex = sb_q.pop_front();
    total++;
    if (fo == 0 || (rd & ex.m) !== (ex.d & ex.m)) begin
      bad++; $display("FAIL zw_read_data: got=%h oe_at=%0d want=%h", rd, fo, ex.d);
    end
    total++;
    if (rl !== 0 || fo !== 2 || oa !== 1'b0) begin
      bad++; $display("FAIL zw_read_timing: ready_low=%0d oe_at=%0d oe_after=%b want 0 2 0", rl, fo, oa);
    end
    bus_cycle(1'b0, 1'b0, 1'b0, 20'h00010, 1'b0, 1'b1, 1'b0, 16'h0000, rl, er, fo, rd, oa);
    total++;
    if (rl !== 0 || er !== 0 || fo !== 0) begin
      bad++; $display("FAIL cs_low_ignored: ready_low=%0d err=%0d oe_at=%0d want 0 0 0", rl, er, fo);
    end
  endtask

  initial begin
    RESET = 1'b1; cs_a = 1'b0; cs_b = 1'b0; ALE = 1'b0; IOM = 1'b0;
    Address = 20'h00000; BHE_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; DataIn = 16'h0000;
    test_reset();
    test_mem_rw();
    test_io_lanes();
    test_both_strobes();
    test_range();
    test_reset_mid_cycle();
    test_zero_wait();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: entries=%0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
